lsu_mem_master: RTL

Core-side load/store initiator for the word-addressed data memory. Accepts one load or store request per transaction over a valid/ready handshake and checks mask legality, alignment and address range. It then drives the memory's `addr/wdata/mask/wr_en/rd_en` strobes and returns a registered response with the loaded data or an error code. It sits between the execute/cache-controller request path and the data memory.

---
 rtl/lsu_mem_master_if.sv | 32 +++
 rtl/lsu_mem_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master_if.sv
// Request/response and data-memory bus of the LSU memory master.
// The master modport is the LSU side; the slave modport is the core plus memory side.
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_mask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_mask;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_mask, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_wdata, mem_mask, mem_wr_en, mem_rd_en
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_mask, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_wdata, mem_mask, mem_wr_en, mem_rd_en
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the word-addressed data memory; all outputs are registered.
// Optional macro LSU_MISALIGN_SPLIT_EN services misaligned H/HU/W as byte-sequential accesses.
module lsu_mem_master #(
    parameter int MEM_WORDS = 1024
) (
    input  logic             i_clk,
    input  logic             i_reset,
    lsu_mem_master_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
`ifdef LSU_MISALIGN_SPLIT_EN
        , ST_SPLIT = 2'd3
`endif
    } state_t;

    localparam logic [29:0] LP_MEM_WORDS = 30'(MEM_WORDS);

    function automatic logic f_mask_legal(input logic we, input logic [2:0] mask);
        case (mask)
            3'b000, 3'b001, 3'b010: return 1'b1;
            3'b100, 3'b101:         return !we;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic f_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b01:   return lo[0];
            2'b10:   return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] f_size_m1(input logic [1:0] sz);
        case (sz)
            2'b01:   return 3'd1;
            2'b10:   return 3'd3;
            default: return 3'd0;
        endcase
    endfunction

`ifdef LSU_MISALIGN_SPLIT_EN
    function automatic logic [31:0] f_extend(input logic [2:0] mask, input logic [31:0] v);
        case (mask)
            3'b001:  return {{16{v[15]}}, v[15:0]};
            3'b101:  return {16'd0, v[15:0]};
            default: return v;
        endcase
    endfunction
`endif

    state_t      r_state, w_nxt_state;
    logic        r_req_ready, w_nxt_req_ready;
    logic        r_rsp_valid, w_nxt_rsp_valid;
    logic [31:0] r_rsp_rdata, w_nxt_rsp_rdata;
    logic [1:0]  r_rsp_err, w_nxt_rsp_err;
    logic [31:0] r_mem_addr, w_nxt_mem_addr;
    logic [31:0] r_mem_wdata, w_nxt_mem_wdata;
    logic [2:0]  r_mem_mask, w_nxt_mem_mask;
    logic        r_mem_wr_en, w_nxt_mem_wr_en;
    logic        r_mem_rd_en, w_nxt_mem_rd_en;

    logic        w_accept, w_legal, w_misal, w_word_inc, w_last_carry, w_fault;
    logic [2:0]  w_size_m1;
    logic [29:0] w_last_idx;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        r_we, w_nxt_we;
    logic [31:0] r_addr, w_nxt_addr;
    logic [31:0] r_wdata, w_nxt_wdata;
    logic [2:0]  r_mask, w_nxt_mask;
    logic [1:0]  r_cnt, w_nxt_cnt, w_cnt_inc, w_cnt_last;
    logic [31:0] r_asm, w_nxt_asm, w_lane;

    assign w_cnt_inc  = r_cnt + 2'd1;
    assign w_cnt_last = (r_mask == 3'b010) ? 2'd3 : 2'd1;
`endif

    // Last-byte word index: a carry out of the low two bits bumps the word, a carry out of bit 31 faults.
    assign w_accept   = bus.req_valid && r_req_ready;
    assign w_legal    = f_mask_legal(bus.req_we, bus.req_mask);
    assign w_misal    = f_misaligned(bus.req_mask[1:0], bus.req_addr[1:0]);
    assign w_size_m1  = f_size_m1(bus.req_mask[1:0]);
    assign w_word_inc = (({1'b0, bus.req_addr[1:0]} + w_size_m1) > 3'd3);
    assign {w_last_carry, w_last_idx} = {1'b0, bus.req_addr[31:2]} + {30'd0, w_word_inc};
    assign w_fault    = w_last_carry || (bus.req_addr[31:2] >= LP_MEM_WORDS)
                        || (w_last_idx >= LP_MEM_WORDS);

    // Next-state and next-output logic.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_rsp_valid = r_rsp_valid;
        w_nxt_rsp_rdata = r_rsp_rdata;
        w_nxt_rsp_err   = r_rsp_err;
        w_nxt_mem_addr  = 32'd0;
        w_nxt_mem_wdata = 32'd0;
        w_nxt_mem_mask  = 3'b000;
        w_nxt_mem_wr_en = 1'b0;
        w_nxt_mem_rd_en = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
        w_nxt_we    = r_we;
        w_nxt_addr  = r_addr;
        w_nxt_wdata = r_wdata;
        w_nxt_mask  = r_mask;
        w_nxt_cnt   = r_cnt;
        w_nxt_asm   = r_asm;
        w_lane      = r_asm;
        w_lane[{r_cnt, 3'b000} +: 8] = bus.mem_rdata[7:0];
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_legal) begin
                        w_nxt_state     = ST_RESP;
                        w_nxt_rsp_valid = 1'b1;
                        w_nxt_rsp_rdata = 32'd0;
                        w_nxt_rsp_err   = 2'b11;
                    end else if (w_misal) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        if (w_fault) begin
                            w_nxt_state     = ST_RESP;
                            w_nxt_rsp_valid = 1'b1;
                            w_nxt_rsp_rdata = 32'd0;
                            w_nxt_rsp_err   = 2'b10;
                        end else begin
                            w_nxt_state     = ST_SPLIT;
                            w_nxt_we        = bus.req_we;
                            w_nxt_addr      = bus.req_addr;
                            w_nxt_wdata     = bus.req_wdata;
                            w_nxt_mask      = bus.req_mask;
                            w_nxt_cnt       = 2'd0;
                            w_nxt_asm       = 32'd0;
                            w_nxt_mem_addr  = bus.req_addr;
                            w_nxt_mem_mask  = bus.req_we ? 3'b000 : 3'b100;
                            w_nxt_mem_wdata = bus.req_we ? {24'd0, bus.req_wdata[7:0]} : 32'd0;
                            w_nxt_mem_wr_en = bus.req_we;
                            w_nxt_mem_rd_en = !bus.req_we;
                        end
`else
                        w_nxt_state     = ST_RESP;
                        w_nxt_rsp_valid = 1'b1;
                        w_nxt_rsp_rdata = 32'd0;
                        w_nxt_rsp_err   = 2'b01;
`endif
                    end else if (w_fault) begin
                        w_nxt_state     = ST_RESP;
                        w_nxt_rsp_valid = 1'b1;
                        w_nxt_rsp_rdata = 32'd0;
                        w_nxt_rsp_err   = 2'b10;
                    end else begin
                        w_nxt_state     = ST_ACCESS;
                        w_nxt_mem_addr  = bus.req_addr;
                        w_nxt_mem_wdata = bus.req_wdata;
                        w_nxt_mem_mask  = bus.req_mask;
                        w_nxt_mem_wr_en = bus.req_we;
                        w_nxt_mem_rd_en = !bus.req_we;
                    end
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                w_nxt_state     = ST_RESP;
                w_nxt_rsp_valid = 1'b1;
                w_nxt_rsp_rdata = r_mem_rd_en ? bus.mem_rdata : 32'd0;
                w_nxt_rsp_err   = 2'b00;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_SPLIT: begin
                if (r_cnt == w_cnt_last) begin
                    w_nxt_state     = ST_RESP;
                    w_nxt_cnt       = 2'd0;
                    w_nxt_asm       = w_lane;
                    w_nxt_rsp_valid = 1'b1;
                    w_nxt_rsp_rdata = r_we ? 32'd0 : f_extend(r_mask, w_lane);
                    w_nxt_rsp_err   = 2'b00;
                end else begin
                    w_nxt_cnt       = w_cnt_inc;
                    w_nxt_asm       = w_lane;
                    w_nxt_mem_addr  = r_addr + {30'd0, w_cnt_inc};
                    w_nxt_mem_mask  = r_we ? 3'b000 : 3'b100;
                    w_nxt_mem_wdata = r_we ? {24'd0, r_wdata[{w_cnt_inc, 3'b000} +: 8]} : 32'd0;
                    w_nxt_mem_wr_en = r_we;
                    w_nxt_mem_rd_en = !r_we;
                end
            end
`endif
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_nxt_state     = ST_IDLE;
                    w_nxt_rsp_valid = 1'b0;
                    w_nxt_rsp_rdata = 32'd0;
                    w_nxt_rsp_err   = 2'b00;
                end else begin
                    w_nxt_state     = ST_RESP;
                end
            end
            default: begin
                w_nxt_state     = ST_IDLE;
                w_nxt_rsp_valid = 1'b0;
                w_nxt_rsp_rdata = 32'd0;
                w_nxt_rsp_err   = 2'b00;
            end
        endcase
        w_nxt_req_ready = (w_nxt_state == ST_IDLE);
    end

    // State, capture and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 2'b00;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_mask  <= 3'b000;
            r_mem_wr_en <= 1'b0;
            r_mem_rd_en <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_mask      <= 3'b000;
            r_cnt       <= 2'd0;
            r_asm       <= 32'd0;
`endif
        end else begin
            r_state     <= w_nxt_state;
            r_req_ready <= w_nxt_req_ready;
            r_rsp_valid <= w_nxt_rsp_valid;
            r_rsp_rdata <= w_nxt_rsp_rdata;
            r_rsp_err   <= w_nxt_rsp_err;
            r_mem_addr  <= w_nxt_mem_addr;
            r_mem_wdata <= w_nxt_mem_wdata;
            r_mem_mask  <= w_nxt_mem_mask;
            r_mem_wr_en <= w_nxt_mem_wr_en;
            r_mem_rd_en <= w_nxt_mem_rd_en;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_we        <= w_nxt_we;
            r_addr      <= w_nxt_addr;
            r_wdata     <= w_nxt_wdata;
            r_mask      <= w_nxt_mask;
            r_cnt       <= w_nxt_cnt;
            r_asm       <= w_nxt_asm;
`endif
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_mask  = r_mem_mask;
    assign bus.mem_wr_en = r_mem_wr_en;
    assign bus.mem_rd_en = r_mem_rd_en;

endmodule
